// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge.
//   state_t      : access FSM states
//   PHASE_LO/HI  : 16-bit phase index within a 32-bit word
//   OOR_RDATA    : read data returned for out-of-range word addresses
//   phase_lanes  : byte-select pair that belongs to a phase
package wb_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam logic PHASE_LO = 1'b0;
    localparam logic PHASE_HI = 1'b1;

    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    // Strobe width counter is 4 bits wide, enough for WAIT_CYCLES up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

    // Byte selects {upper, lower} that drive the SRAM lanes in a given phase.
    function automatic logic [1:0] phase_lanes(input logic [3:0] sel, input logic ph);
        logic [1:0] lanes;
        if (ph == PHASE_HI) begin
            lanes = sel[3:2];
        end else begin
            lanes = sel[1:0];
        end
        return lanes;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the SRAM strobe pulse.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over en)
//   en         : count down by one while non-zero
//   load_val   : value loaded, WAIT_CYCLES-1 for a WAIT_CYCLES wide strobe
//   done       : count has reached zero (last strobe cycle)
module sram_wait_counter
    import wb_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  en,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] count_r;

    // Down-counter: load has priority, saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == 4'd0);

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave driving an external asynchronous 16-bit SRAM.
// Each 32-bit word access is split into up to two 16-bit phases (low half
// first), each phase being SETUP, WAIT_CYCLES of STROBE, then HOLD.
//   clk, rst          : clock, async active-low reset
//   i_wbs_*           : Wishbone slave request (we, cyc, stb, sel, adr, dat)
//   o_wbs_dat/ack/int : Wishbone response (int is always 0)
//   o_sram_adr/dq     : SRAM halfword address and write data
//   i_sram_dq         : SRAM read data
//   o_sram_dq_oe      : data pad output enable (write phases only)
//   o_sram_*_n        : active-low SRAM strobes and byte lanes
// All outputs are registered from a decode of the FSM state, so every
// output lags the state register by one clock.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wbs_we,
    input  logic                  i_wbs_cyc,
    input  logic                  i_wbs_stb,
    input  logic [3:0]            i_wbs_sel,
    input  logic [31:0]           i_wbs_adr,
    input  logic [31:0]           i_wbs_dat,
    output logic [31:0]           o_wbs_dat,
    output logic                  o_wbs_ack,
    output logic                  o_wbs_int,
    output logic [ADDR_WIDTH-1:0] o_sram_adr,
    output logic [15:0]           o_sram_dq,
    input  logic [15:0]           i_sram_dq,
    output logic                  o_sram_dq_oe,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic                  o_sram_ub_n,
    output logic                  o_sram_lb_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                  state_r, state_s;
    logic                    phase_r, phase_s;
    logic                    abort_r, abort_s;
    logic                    we_r;
    logic [3:0]              sel_r;
    logic [ADDR_WIDTH-2:0]   adr_r;
    logic [31:0]             dat_r;
    logic [31:0]             rdata_r;

    logic                    accept_s;
    logic                    capture_s;
    logic                    cnt_load_s;
    logic                    cnt_en_s;
    logic                    cnt_done_s;
    logic                    oor_s;
    logic                    need_hi_s;

    logic                    active_s;
    logic [1:0]              lanes_s;
    logic                    ce_n_s, oe_n_s, we_n_s, ub_n_s, lb_n_s, dq_oe_s, ack_s;
    logic [ADDR_WIDTH-1:0]   sram_adr_s;
    logic [15:0]             sram_dq_s;
    logic [31:0]             wbs_dat_s;

    // Any word address at or above 2^(ADDR_WIDTH-1) has no backing SRAM.
    assign oor_s = |i_wbs_adr[31:ADDR_WIDTH-1];

    // Writes need the high phase only when an upper byte is selected.
    assign need_hi_s = !we_r || (sel_r[3:2] != 2'b00);

    sram_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (WAIT_LOAD),
        .done     (cnt_done_s)
    );

    // FSM state, phase and master-abort flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            phase_r <= PHASE_LO;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            abort_r <= accept_s ? 1'b0 : abort_s;
        end
    end

    // Next-state logic plus counter and read-capture controls.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        // A cyc drop anywhere inside a phase is remembered; the phase still
        // runs to HOLD so a we_n pulse is never cut short.
        if ((state_r != ST_IDLE) && (state_r != ST_ACK) && !i_wbs_cyc) begin
            abort_s = 1'b1;
        end else begin
            abort_s = abort_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (i_wbs_cyc && i_wbs_stb && !o_wbs_ack) begin
                    accept_s = 1'b1;
                    if (oor_s || (i_wbs_we && (i_wbs_sel == 4'b0000))) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_SETUP;
                        if (i_wbs_we && (i_wbs_sel[1:0] == 2'b00)) begin
                            phase_s = PHASE_HI;
                        end else begin
                            phase_s = PHASE_LO;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s    = ST_STROBE;
                cnt_load_s = 1'b1;
            end
            ST_STROBE: begin
                cnt_en_s = 1'b1;
                if (cnt_done_s) begin
                    state_s   = ST_HOLD;
                    capture_s = !we_r;
                end else begin
                    state_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if ((phase_r == PHASE_LO) && need_hi_s) begin
                    state_s = ST_SETUP;
                    phase_s = PHASE_HI;
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request latch at acceptance and read-data assembly per phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            sel_r   <= 4'b0000;
            adr_r   <= {(ADDR_WIDTH-1){1'b0}};
            dat_r   <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= i_wbs_we;
            sel_r   <= i_wbs_sel;
            adr_r   <= i_wbs_adr[ADDR_WIDTH-2:0];
            dat_r   <= i_wbs_dat;
            rdata_r <= OOR_RDATA;
        end else if (capture_s) begin
            if (phase_r == PHASE_HI) begin
                rdata_r[31:16] <= i_sram_dq;
            end else begin
                rdata_r[15:0] <= i_sram_dq;
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Output decode of the current state; registered below.
    always_comb begin
        active_s   = (state_r == ST_SETUP) || (state_r == ST_STROBE) || (state_r == ST_HOLD);
        lanes_s    = phase_lanes(sel_r, phase_r);
        ce_n_s     = 1'b1;
        oe_n_s     = 1'b1;
        we_n_s     = 1'b1;
        ub_n_s     = 1'b1;
        lb_n_s     = 1'b1;
        dq_oe_s    = 1'b0;
        ack_s      = 1'b0;
        sram_adr_s = {ADDR_WIDTH{1'b0}};
        sram_dq_s  = 16'h0000;
        wbs_dat_s  = o_wbs_dat;
        if (active_s) begin
            ce_n_s     = 1'b0;
            sram_adr_s = {adr_r, phase_r};
            if (we_r) begin
                dq_oe_s   = 1'b1;
                sram_dq_s = (phase_r == PHASE_HI) ? dat_r[31:16] : dat_r[15:0];
                lb_n_s    = !lanes_s[0];
                ub_n_s    = !lanes_s[1];
            end else begin
                lb_n_s = 1'b0;
                ub_n_s = 1'b0;
            end
            if (state_r == ST_STROBE) begin
                we_n_s = !we_r;
                oe_n_s = we_r;
            end else begin
                we_n_s = 1'b1;
                oe_n_s = 1'b1;
            end
        end else begin
            ce_n_s = 1'b1;
        end
        if (state_r == ST_ACK) begin
            ack_s = 1'b1;
            // Read data is published together with ack; writes leave it alone.
            if (!we_r) begin
                wbs_dat_s = rdata_r;
            end else begin
                wbs_dat_s = o_wbs_dat;
            end
        end else begin
            ack_s = 1'b0;
        end
    end

    // Output registers; reset drives every strobe inactive immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wbs_dat    <= 32'h0000_0000;
            o_wbs_ack    <= 1'b0;
            o_wbs_int    <= 1'b0;
            o_sram_adr   <= {ADDR_WIDTH{1'b0}};
            o_sram_dq    <= 16'h0000;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
        end else begin
            o_wbs_dat    <= wbs_dat_s;
            o_wbs_ack    <= ack_s;
            o_wbs_int    <= 1'b0;
            o_sram_adr   <= sram_adr_s;
            o_sram_dq    <= sram_dq_s;
            o_sram_dq_oe <= dq_oe_s;
            o_sram_ce_n  <= ce_n_s;
            o_sram_oe_n  <= oe_n_s;
            o_sram_we_n  <= we_n_s;
            o_sram_ub_n  <= ub_n_s;
            o_sram_lb_n  <= lb_n_s;
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: a word/byte-level reference model
// predicts ack timing, read data and SRAM write phases; a monitor with an
// attached behavioural SRAM compares them as the DUT produces them.
module tb_wb_sram_slave;

    localparam int AW    = 19;
    localparam int W     = 2;
    localparam int PH    = W + 2;
    localparam int LIMIT = 32'h0004_0000;

    logic        clk;
    logic        rst;
    logic        i_wbs_we, i_wbs_cyc, i_wbs_stb;
    logic [3:0]  i_wbs_sel;
    logic [31:0] i_wbs_adr, i_wbs_dat;
    logic [31:0] o_wbs_dat;
    logic        o_wbs_ack, o_wbs_int;
    logic [AW-1:0] o_sram_adr;
    logic [15:0] o_sram_dq, i_sram_dq;
    logic        o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n;

    wb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .i_wbs_we(i_wbs_we), .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb),
        .i_wbs_sel(i_wbs_sel), .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
        .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack), .o_wbs_int(o_wbs_int),
        .o_sram_adr(o_sram_adr), .o_sram_dq(o_sram_dq), .i_sram_dq(i_sram_dq),
        .o_sram_dq_oe(o_sram_dq_oe), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
        .o_sram_we_n(o_sram_we_n), .o_sram_ub_n(o_sram_ub_n), .o_sram_lb_n(o_sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned cyc_cnt = 0;
    int ce_lo_total = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct { int unsigned cyc; logic [31:0] dat; } exp_t;
    typedef struct { logic [AW-1:0] adr; logic [15:0] dq; logic ub_n; logic lb_n; } wr_t;
    exp_t ack_q[$];
    wr_t  wr_q[$];

    // Behavioural SRAM (halfwords) and word-level reference memory.
    logic [15:0] sram    [0:511] = '{default: 16'h0000};
    logic [31:0] ref_mem [0:255] = '{default: 32'h0000_0000};
    logic [31:0] last_rd = 32'h0000_0000;

    assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? sram[o_sram_adr[8:0]] : 16'hA5A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pulse widths, write phases, read turnaround, ack scoreboard.
    int  we_cnt = 0;
    int  oe_cnt = 0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            we_cnt = 0;
            oe_cnt = 0;
            prev_ack = 1'b0;
        end else begin
            if (!o_sram_ce_n) ce_lo_total++;
            if (!o_sram_we_n) begin
                we_cnt++;
            end else if (we_cnt != 0) begin
                chk("we_width", we_cnt, W);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t r;
                    r = wr_q.pop_front();
                    chk("wr_adr", 32'(o_sram_adr), 32'(r.adr));
                    chk("wr_dq", 32'(o_sram_dq), 32'(r.dq));
                    chk("wr_ub_n", 32'(o_sram_ub_n), 32'(r.ub_n));
                    chk("wr_lb_n", 32'(o_sram_lb_n), 32'(r.lb_n));
                    chk("wr_ce_held", 32'(o_sram_ce_n), 0);
                end
                if (!o_sram_ce_n && !o_sram_ub_n) sram[o_sram_adr[8:0]][15:8] = o_sram_dq[15:8];
                if (!o_sram_ce_n && !o_sram_lb_n) sram[o_sram_adr[8:0]][7:0]  = o_sram_dq[7:0];
                we_cnt = 0;
            end
            if (!o_sram_oe_n) begin
                oe_cnt++;
                chk("dq_oe_on_read", 32'(o_sram_dq_oe), 0);
            end else if (oe_cnt != 0) begin
                chk("oe_width", oe_cnt, W);
                oe_cnt = 0;
            end
            if (prev_ack) chk("ack_single", 32'(o_wbs_ack), 0);
            if (o_wbs_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = ack_q.pop_front();
                    chk("ack_cycle", cyc_cnt, e.cyc);
                    chk("rdata", o_wbs_dat, e.dat);
                    chk("int_zero", 32'(o_wbs_int), 0);
                end
            end
            prev_ack = o_wbs_ack;
        end
    end

    function automatic int n_phases(input logic we, input logic [31:0] adr, input logic [3:0] sel);
        if (adr >= LIMIT) return 0;
        if (!we) return 2;
        return ((sel[1:0] != 2'b00) ? 1 : 0) + ((sel[3:2] != 2'b00) ? 1 : 0);
    endfunction

    // Update reference memory and queue expected SRAM write phases.
    task automatic model_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        wr_t r;
        for (int p = 0; p < 2; p++) begin
            if (sel[2*p +: 2] != 2'b00) begin
                r.adr  = AW'(adr * 2 + p);
                r.dq   = dat[16*p +: 16];
                r.ub_n = !sel[2*p+1];
                r.lb_n = !sel[2*p];
                wr_q.push_back(r);
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) ref_mem[adr[7:0]][8*b +: 8] = dat[8*b +: 8];
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        exp_t e;
        int   n;
        int   ce0;
        logic got;
        n = n_phases(we, adr, sel);
        @(posedge clk);
        #1;
        if (adr < LIMIT) begin
            if (we) model_write(adr, sel, dat);
            else    last_rd = ref_mem[adr[7:0]];
        end else if (!we) begin
            last_rd = 32'h0000_0000;
        end
        e.cyc = cyc_cnt + 1 + ((n == 0) ? 1 : (n * PH + 1));
        e.dat = last_rd;
        ack_q.push_back(e);
        ce0 = ce_lo_total;
        i_wbs_we = we; i_wbs_adr = adr; i_wbs_sel = sel; i_wbs_dat = dat;
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (o_wbs_ack) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 0, 1);
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
        @(negedge clk);
        chk("ce_cycles", ce_lo_total - ce0, n * PH);
    endtask

    initial begin
        logic got;
        rst = 1'b0;
        i_wbs_we = 1'b0; i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
        i_wbs_sel = 4'h0; i_wbs_adr = 32'h0; i_wbs_dat = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(o_sram_ce_n), 1);
        chk("rst_oe_n", 32'(o_sram_oe_n), 1);
        chk("rst_we_n", 32'(o_sram_we_n), 1);
        chk("rst_ub_lb", 32'({o_sram_ub_n, o_sram_lb_n}), 3);
        chk("rst_ack", 32'(o_wbs_ack), 0);
        chk("rst_int", 32'(o_wbs_int), 0);
        chk("rst_dq_oe", 32'(o_sram_dq_oe), 0);
        chk("rst_dat", o_wbs_dat, 0);
        chk("rst_adr", 32'(o_sram_adr), 0);
        chk("rst_dq", 32'(o_sram_dq), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Directed cases.
        issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        issue(1'b1, 32'h10, 4'h4, 32'h00AA_0000);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        issue(1'b0, 32'h0004_0000, 4'hF, 32'h0);
        issue(1'b1, 32'h0004_0000, 4'hF, 32'h1234_5678);
        issue(1'b1, 32'h11, 4'h0, 32'hFFFF_FFFF);
        issue(1'b1, 32'h12, 4'h3, 32'h1111_2222);

        // Master abort during phase-0 strobe of a full write.
        @(posedge clk); #1;
        model_write(32'h20, 4'h3, 32'hCAFE_F00D);
        i_wbs_we = 1'b1; i_wbs_adr = 32'h20; i_wbs_sel = 4'hF; i_wbs_dat = 32'hCAFE_F00D;
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!o_sram_we_n) got = 1'b1;
        end
        chk("abort_we_seen", 32'(got), 1);
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_ce_idle", 32'(o_sram_ce_n), 1);
        chk("abort_no_phase1", wr_q.size(), 0);
        issue(1'b0, 32'h20, 4'hF, 32'h0);

        // Reset asserted in the middle of a read.
        @(posedge clk); #1;
        i_wbs_we = 1'b0; i_wbs_adr = 32'h10; i_wbs_sel = 4'hF;
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!o_sram_oe_n) got = 1'b1;
        end
        chk("rstmid_oe_seen", 32'(got), 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_ce_n", 32'(o_sram_ce_n), 1);
        chk("rstmid_oe_n", 32'(o_sram_oe_n), 1);
        chk("rstmid_we_n", 32'(o_sram_we_n), 1);
        chk("rstmid_ub_lb", 32'({o_sram_ub_n, o_sram_lb_n}), 3);
        chk("rstmid_ack", 32'(o_wbs_ack), 0);
        last_rd = 32'h0000_0000;
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        issue(1'b0, 32'h10, 4'hF, 32'h0);

        // Randomised traffic.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = 32'h0004_0000 + $urandom_range(0, 1000);
            else                           a = $urandom_range(0, 255);
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("ack_q_drained", ack_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
